mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Layer sequencer for a single `mac` lane in the MNIST streamline datapath. On a start command it clears the accumulator and streams one input vector of `n_in` elements per output group. It issues image and weight read addresses, and delays `acc_en` to match the memory and MAC pipeline. It then optionally applies ReLU and holds the result valid until downstream accepts it. It sits between the layer-level top FSM and the MAC/feature and weight memories.

## Interface
- `AW`, 16 — address width for image and weight reads.
- `CW`, 16 — width of `n_in_i` and `n_grp_i` counters.
- `ACC_DLY`, 3 — cycles from `rd_en` to matching `acc_en`:
  - 1 cycle of memory read latency;
  - 1 cycle for the MAC operand register;
  - 1 cycle for the MAC product register.
- `clk_i` in 1 — clock, all logic on rising edge.
- `rst_i` in 1 — synchronous reset, active-high.
- `start_i` in 1 — start pulse; sampled only in IDLE.
- `n_in_i` in CW — inputs per group; latched on accepted start.
- `n_grp_i` in CW — number of output groups; latched on accepted start.
- `relu_i` in 1 — apply ReLU per group; latched on accepted start.
- `out_ready_i` in 1 — downstream accepts the current result.
- `img_addr_o` out AW — image read address.
- `wgt_addr_o` out AW — weight read address.
- `rd_en_o` out 1 — memory read strobe.
- `acc_en_o` out 1 — to `mac.acc_en`.
- `relu_en_o` out 1 — to `mac.relu_en`.
- `mac_clear_o` out 1 — to `mac.mac_clear`.
- `out_valid_o` out 1 — MAC output holds the finished group result.
- `out_grp_o` out CW — index of the group being presented.
- `busy_o` out 1 — state is not IDLE.
- `done_o` out 1 — one-cycle pulse at layer completion.

## Operation
- States:
  - IDLE.
  - CLEAR: `mac_clear_o`=1 for 1 cycle.
  - FEED: `rd_en_o`=1 for `n_in` cycles. `img_addr_o` runs 0..n_in-1. `wgt_addr_o` increments every FEED cycle.
  - DRAIN: ACC_DLY cycles.
  - RELU: `relu_en_o`=1 for 1 cycle. Skipped when the latched relu is 0.
  - OUT: `out_valid_o`=1.
  - DONE: `done_o`=1 for 1 cycle.
- Transitions:
  - IDLE→CLEAR on `start_i` with n_in≠0 and n_grp≠0.
  - IDLE→DONE on `start_i` with either count 0. No other strobe is asserted in that case.
  - CLEAR→FEED.
  - FEED→DRAIN after the n_in-th cycle.
  - DRAIN→RELU or OUT.
  - RELU→OUT.
  - OUT→CLEAR when `out_ready_i`=1 and this is not the last group; the group counter increments.
  - OUT→DONE when `out_ready_i`=1 on the last group.
  - DONE→IDLE.
- `acc_en_o` is `rd_en_o` delayed ACC_DLY cycles through a shift register.
- `wgt_addr_o` is group-major: it resets to 0 on an accepted start and is never reset between groups, so group g reads g·n_in..g·n_in+n_in-1.
- `img_addr_o` resets to 0 in every CLEAR.
- `acc_en_o`, `relu_en_o` and `mac_clear_o` are mutually exclusive in every cycle. The MAC's own priority is never relied on.
- `start_i` while busy is ignored. Config inputs are don't-care outside the accepting cycle.
- `out_grp_o` equals the current group index in every state after start; it is 0 in IDLE.
- Address counters wrap modulo 2^AW. The user must keep n_in·n_grp ≤ 2^AW.

## Timing
- All outputs are registered. Reset value of every output is 0, and the `acc_en` shift register is 0.
- `rst_i` mid-operation: next cycle the state is IDLE, all outputs are 0 and the delay line is flushed. The MAC contents are left as-is.
- Start sampled in cycle 0 → CLEAR in cycle 1, FEED in cycles 2..n_in+1.
- First `acc_en_o` is in cycle 2+ACC_DLY. Last `acc_en_o` is in cycle n_in+1+ACC_DLY, which is the last DRAIN cycle.
- The MAC result is final (post-ReLU if enabled) in the first OUT cycle.
- Per-group cycles with ready held high = 1 + n_in + ACC_DLY + relu + 1.
- OUT holds with `out_valid_o`=1 and all MAC strobes 0 for as long as `out_ready_i`=0.

## Test plan
- n_in=4, n_grp=2, relu=1, ready=1, start in cycle 0:
  - `mac_clear` in cycles 1 and 11; `rd_en` in 2–5 and 12–15; `acc_en` in 5–8 and 15–18.
  - `relu_en` in 9 and 19; `out_valid` in 10 (grp 0) and 20 (grp 1).
  - `done` in 21; `busy` in 1–21.
  - `wgt_addr` 0..3 then 4..7; `img_addr` 0..3 twice.
- Same config with relu=0: no `relu_en`; `out_valid` in 9 and 18; `done` in 19.
- Same config as the first scenario with ready=0 for 5 cycles of group 0's OUT: `out_valid` held in cycles 10–15 with no strobes, then CLEAR in 16. The MAC output with a negative preload is 0 after ReLU.
- n_grp=0 start: `done` in cycle 1 only, no `rd_en`/`mac_clear`. A second start while busy (n_in=4 run) is ignored and the counts are unchanged.
- Assert `rst_i` in cycle 4 of a FEED: all outputs 0 from cycle 5, and no `acc_en` emerges from the delay line. A fresh start then reproduces the first scenario exactly.
- Check every cycle that at most one of `acc_en`, `relu_en` and `mac_clear` is high.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Layer sequencer for one MAC lane: clears, feeds n_in operands per group,
// waits out the memory/MAC pipeline, optionally applies ReLU and presents results.
module mac_seq_ctrl #(
    parameter int unsigned AW      = 16,
    parameter int unsigned CW      = 16,
    parameter int unsigned ACC_DLY = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [CW-1:0] n_in_i,
    input  logic [CW-1:0] n_grp_i,
    input  logic          relu_i,
    input  logic          out_ready_i,
    output logic [AW-1:0] img_addr_o,
    output logic [AW-1:0] wgt_addr_o,
    output logic          rd_en_o,
    output logic          acc_en_o,
    output logic          relu_en_o,
    output logic          mac_clear_o,
    output logic          out_valid_o,
    output logic [CW-1:0] out_grp_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_RELU,
        S_OUT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_n_in;
    logic [CW-1:0]      r_n_grp;
    logic [CW-1:0]      r_cnt;
    logic               r_relu;
    logic [ACC_DLY-1:0] r_dly;
    logic               w_start_acc;
    logic               w_last_grp;
    logic               w_rd_nxt;

    assign w_start_acc = (r_state == S_IDLE) && start_i;
    assign w_last_grp  = (out_grp_o == (r_n_grp - CW'(1)));
    assign w_rd_nxt    = (w_state_nxt == S_FEED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if ((n_in_i == CW'(0)) || (n_grp_i == CW'(0))) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR: w_state_nxt = S_FEED;
            S_FEED: begin
                if (r_cnt == (r_n_in - CW'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == CW'(ACC_DLY - 1)) begin
                    w_state_nxt = r_relu ? S_RELU : S_OUT;
                end
            end
            S_RELU: w_state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready_i) begin
                    w_state_nxt = w_last_grp ? S_DONE : S_CLEAR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with their state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_n_in      <= '0;
            r_n_grp     <= '0;
            r_relu      <= 1'b0;
            r_cnt       <= '0;
            r_dly       <= '0;
            img_addr_o  <= '0;
            wgt_addr_o  <= '0;
            rd_en_o     <= 1'b0;
            acc_en_o    <= 1'b0;
            relu_en_o   <= 1'b0;
            mac_clear_o <= 1'b0;
            out_valid_o <= 1'b0;
            out_grp_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_n_in     <= n_in_i;
                r_n_grp    <= n_grp_i;
                r_relu     <= relu_i;
                wgt_addr_o <= '0;
            end else if (r_state == S_FEED) begin
                wgt_addr_o <= wgt_addr_o + AW'(1);
            end

            if (w_state_nxt == S_CLEAR) begin
                img_addr_o <= '0;
            end else if (r_state == S_FEED) begin
                img_addr_o <= img_addr_o + AW'(1);
            end

            r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);

            if (w_start_acc || (w_state_nxt == S_IDLE)) begin
                out_grp_o <= '0;
            end else if ((r_state == S_OUT) && (w_state_nxt == S_CLEAR)) begin
                out_grp_o <= out_grp_o + CW'(1);
            end

            // Delay line: tap k carries rd_en_o delayed by k cycles.
            r_dly       <= ACC_DLY'({r_dly, w_rd_nxt});
            acc_en_o    <= r_dly[ACC_DLY-1];
            rd_en_o     <= w_rd_nxt;
            relu_en_o   <= (w_state_nxt == S_RELU);
            mac_clear_o <= (w_state_nxt == S_CLEAR);
            out_valid_o <= (w_state_nxt == S_OUT);
            busy_o      <= (w_state_nxt != S_IDLE);
            done_o      <= (w_state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: timeline model of each group's strobe windows, checked every cycle,
// plus literal event-cycle expectations for the directed scenarios.
module tb_mac_seq_ctrl;
    localparam int AW = 16;
    localparam int CW = 16;
    localparam int D  = 3;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [CW-1:0] n_in_i;
    logic [CW-1:0] n_grp_i;
    logic          relu_i;
    logic          out_ready_i;
    logic [AW-1:0] img_addr_o;
    logic [AW-1:0] wgt_addr_o;
    logic          rd_en_o;
    logic          acc_en_o;
    logic          relu_en_o;
    logic          mac_clear_o;
    logic          out_valid_o;
    logic [CW-1:0] out_grp_o;
    logic          busy_o;
    logic          done_o;

    mac_seq_ctrl #(.AW(AW), .CW(CW), .ACC_DLY(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .n_in_i      (n_in_i),
        .n_grp_i     (n_grp_i),
        .relu_i      (relu_i),
        .out_ready_i (out_ready_i),
        .img_addr_o  (img_addr_o),
        .wgt_addr_o  (wgt_addr_o),
        .rd_en_o     (rd_en_o),
        .acc_en_o    (acc_en_o),
        .relu_en_o   (relu_en_o),
        .mac_clear_o (mac_clear_o),
        .out_valid_o (out_valid_o),
        .out_grp_o   (out_grp_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s0     = 0;

    // Model: mode 0 idle, 1 running a group that started CLEAR at m_t0, 2 done pulse.
    int m_mode = 0;
    int m_t0   = 0;
    int m_grp  = 0;
    int m_n    = 0;
    int m_g    = 0;
    int m_relu = 0;
    int m_rst  = 0;

    int lg_clear[$];
    int lg_relu[$];
    int lg_out[$];
    int lg_done[$];
    int lg_acc[$];
    int lg_rd[$];
    int lg_img[$];
    int lg_wgt[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input int act[$], input int exp[$]);
        chk({name, "_count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++) begin
            chk(name, act[i], exp[i]);
        end
    endtask

    task automatic model_update(input bit s, input int n, input int g, input bit rl,
                                input bit rdy, input bit rs);
        int rel;
        m_rst = rs;
        if (rs) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (s) begin
                        m_n    = n;
                        m_g    = g;
                        m_relu = rl;
                        m_grp  = 0;
                        if (n == 0 || g == 0) begin
                            m_mode = 2;
                        end else begin
                            m_mode = 1;
                            m_t0   = cyc + 1;
                        end
                    end
                end
                1: begin
                    rel = cyc - m_t0;
                    if (rel >= m_n + D + 1 + m_relu && rdy) begin
                        if (m_grp == m_g - 1) begin
                            m_mode = 2;
                        end else begin
                            m_grp = m_grp + 1;
                            m_t0  = cyc + 1;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic check_cycle();
        int rel;
        int k;
        int e_clr, e_rd, e_acc, e_relu, e_out, e_busy, e_done, e_grp;
        e_clr = 0; e_rd = 0; e_acc = 0; e_relu = 0; e_out = 0;
        e_busy = 0; e_done = 0; e_grp = 0; rel = 0;
        if (m_mode == 1) begin
            rel    = cyc - m_t0;
            e_busy = 1;
            e_grp  = m_grp;
            e_clr  = (rel == 0);
            e_rd   = (rel >= 1 && rel <= m_n);
            e_acc  = (rel >= D + 1 && rel <= m_n + D);
            e_relu = (m_relu != 0 && rel == m_n + D + 1);
            e_out  = (rel >= m_n + D + 1 + m_relu);
        end else if (m_mode == 2) begin
            e_busy = 1;
            e_done = 1;
            e_grp  = m_grp;
        end
        chk("mac_clear", mac_clear_o, e_clr);
        chk("rd_en", rd_en_o, e_rd);
        chk("acc_en", acc_en_o, e_acc);
        chk("relu_en", relu_en_o, e_relu);
        chk("out_valid", out_valid_o, e_out);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("out_grp", out_grp_o, e_grp);
        chk("strobe_exclusive", (int'(acc_en_o) + int'(relu_en_o) + int'(mac_clear_o)) <= 1, 1);
        if (e_rd != 0) begin
            chk("img_addr", img_addr_o, rel - 1);
            chk("wgt_addr", wgt_addr_o, (m_grp * m_n + rel - 1) % (1 << AW));
        end
        if (m_rst != 0) begin
            chk("img_addr_rst", img_addr_o, 0);
            chk("wgt_addr_rst", wgt_addr_o, 0);
        end
        k = cyc - s0;
        if (mac_clear_o) lg_clear.push_back(k);
        if (relu_en_o)   lg_relu.push_back(k);
        if (out_valid_o) lg_out.push_back(k);
        if (done_o)      lg_done.push_back(k);
        if (acc_en_o)    lg_acc.push_back(k);
        if (rd_en_o) begin
            lg_rd.push_back(k);
            lg_img.push_back(int'(img_addr_o));
            lg_wgt.push_back(int'(wgt_addr_o));
        end
    endtask

    task automatic tick(input bit s, input int n, input int g, input bit rl,
                        input bit rdy, input bit rs);
        start_i     = s;
        n_in_i      = CW'(n);
        n_grp_i     = CW'(g);
        relu_i      = rl;
        out_ready_i = rdy;
        rst_i       = rs;
        model_update(s, n, g, rl, rdy, rs);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic clear_logs();
        lg_clear.delete(); lg_relu.delete(); lg_out.delete(); lg_done.delete();
        lg_acc.delete(); lg_rd.delete(); lg_img.delete(); lg_wgt.delete();
    endtask

    task automatic idle_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tick(1'b0, $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // One layer run: start at relative cycle 0; ready low in [lo,hi]; optional busy start / reset.
    task automatic do_run(input int n, input int g, input bit rl, input int lo, input int hi,
                          input int busy_k, input int rst_k, input bit rnd_rdy);
        bit rdy;
        bit fin;
        clear_logs();
        s0  = cyc;
        fin = 0;
        tick(1'b1, n, g, rl, 1'b1, 1'b0);
        for (int k = 1; k < 2000; k++) begin
            if (m_mode == 0) begin
                fin = 1;
                break;
            end
            rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : !(k >= lo && k <= hi);
            if (k == rst_k) begin
                tick(1'b0, n, g, rl, rdy, 1'b1);
            end else if (k == busy_k) begin
                tick(1'b1, 7, 5, !rl, rdy, 1'b0);
            end else begin
                tick(1'b0, $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom), rdy, 1'b0);
            end
        end
        if (!fin) chk("run_timeout", m_mode, 0);
    endtask

    task automatic check_s1();
        chk_q("s1_clear", lg_clear, '{1, 11});
        chk_q("s1_rd", lg_rd, '{2, 3, 4, 5, 12, 13, 14, 15});
        chk_q("s1_acc", lg_acc, '{5, 6, 7, 8, 15, 16, 17, 18});
        chk_q("s1_relu", lg_relu, '{9, 19});
        chk_q("s1_out", lg_out, '{10, 20});
        chk_q("s1_done", lg_done, '{21});
        chk_q("s1_img", lg_img, '{0, 1, 2, 3, 0, 1, 2, 3});
        chk_q("s1_wgt", lg_wgt, '{0, 1, 2, 3, 4, 5, 6, 7});
    endtask

    initial begin
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle_ticks(2);

        do_run(4, 2, 1'b1, -1, -1, -1, -1, 1'b0);
        check_s1();
        idle_ticks(2);

        do_run(4, 2, 1'b0, -1, -1, -1, -1, 1'b0);
        chk_q("s2_relu", lg_relu, '{});
        chk_q("s2_out", lg_out, '{9, 18});
        chk_q("s2_done", lg_done, '{19});
        idle_ticks(2);

        do_run(4, 2, 1'b1, 10, 14, -1, -1, 1'b0);
        chk_q("s3_out", lg_out, '{10, 11, 12, 13, 14, 15, 25});
        chk_q("s3_clear", lg_clear, '{1, 16});
        chk_q("s3_done", lg_done, '{26});
        idle_ticks(2);

        do_run(4, 0, 1'b1, -1, -1, -1, -1, 1'b0);
        idle_ticks(3);
        chk_q("s4_done", lg_done, '{1});
        chk_q("s4_clear", lg_clear, '{});
        chk_q("s4_rd", lg_rd, '{});

        do_run(4, 2, 1'b1, -1, -1, 3, -1, 1'b0);
        check_s1();
        idle_ticks(2);

        do_run(4, 2, 1'b1, -1, -1, -1, 4, 1'b0);
        idle_ticks(6);
        chk_q("s5_acc", lg_acc, '{});
        chk_q("s5_rd", lg_rd, '{2, 3, 4});
        do_run(4, 2, 1'b1, -1, -1, -1, -1, 1'b0);
        check_s1();
        idle_ticks(2);

        for (int r = 0; r < 150; r++) begin
            int n, g, bk, rk;
            n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            g  = $urandom_range(0, 3);
            bk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
            rk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : -1;
            do_run(n, g, 1'($urandom), -1, -1, bk, rk, 1'b1);
            idle_ticks($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
